// File: rtl/cell_pos_reader.sv
// cell_pos_reader
//   Streams one cell's particle positions out of a single-port position
//   memory (2-cycle read latency) into the force-evaluation pipeline.
//   Address 0 of the memory holds the particle count, addresses 1..N hold
//   {posz, posy, posx}. Returned words are buffered in a small FIFO and
//   presented on a valid/ready handshake with full backpressure.
//
//   Ports:
//     clock, rst_n        system clock, synchronous active-low reset
//     start               one-cycle pulse, begin reading the cell
//     busy, done          cell in progress / one-cycle completion pulse
//     mem_address/rden    position memory read request
//     mem_wren            tied 0, this block never writes
//     mem_q               read data, valid 2 cycles after mem_rden
//     pos_data/index/last particle word, its address, last-particle flag
//     pos_valid/ready     downstream handshake
//     stall_cycles        backpressure perf counter
//
//   Configuration macro:
//     CELL_POS_READER_PERF_EN  enables the stall_cycles counter; when
//                              undefined stall_cycles is tied to 0.
module cell_pos_reader #(
   parameter int unsigned DATA_WIDTH   = 96,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned PARTICLE_NUM = 220,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic [DATA_WIDTH-1:0] pos_data,
   output logic [ADDR_WIDTH-1:0] pos_index,
   output logic                  pos_last,
   output logic                  pos_valid,
   input  logic                  pos_ready,
   output logic [15:0]           stall_cycles
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 2;
   localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

   typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN} state_e;

   state_e                state_q;
   logic                  busy_q, done_q, rden_q, wait_q;
   logic [ADDR_WIDTH-1:0] addr_q, count_q, next_addr_q;

   logic                  st1_vld_q, st2_vld_q;
   logic [ADDR_WIDTH-1:0] st1_addr_q, st2_addr_q;
   logic [EW-1:0]         fifo_mem_q [FIFO_DEPTH];
   logic [PW:0]           wr_ptr_q, rd_ptr_q;

   logic [ADDR_WIDTH-1:0] cnt_sat;
   logic [PW:0]           fifo_used;
   logic [CW-1:0]         occ_d;
   logic                  fifo_empty, push, pop, can_issue, rd_trk;
   logic [EW-1:0]         head;

   always_comb begin
      cnt_sat    = (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];
      fifo_used  = wr_ptr_q - rd_ptr_q;
      fifo_empty = (fifo_used == '0);
      push       = st2_vld_q;
      pop        = !fifo_empty && pos_ready;
      // Only particle reads are tracked; the count read is always address 0.
      rd_trk     = rden_q && (addr_q != '0);
      // Occupancy the FIFO plus read pipeline will have after this edge; a new
      // read is issued only if that leaves a free slot for its return.
      occ_d      = CW'(fifo_used) + CW'(push) + CW'(rd_trk) + CW'(st1_vld_q) - CW'(pop);
      can_issue  = (occ_d < CW'(FIFO_DEPTH));
      head       = fifo_mem_q[rd_ptr_q[PW-1:0]];
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_address = addr_q;
   assign mem_rden    = rden_q;
   assign mem_wren    = 1'b0;
   assign pos_valid   = !fifo_empty;
   assign pos_data    = head[EW-1 -: DATA_WIDTH];
   assign pos_index   = head[ADDR_WIDTH:1];
   assign pos_last    = head[0];

   // Control FSM with registered outputs.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rden_q      <= 1'b0;
         wait_q      <= 1'b0;
         addr_q      <= '0;
         count_q     <= '0;
         next_addr_q <= '0;
      end else begin
         done_q <= 1'b0;
         rden_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= CNT_RD;
                  busy_q  <= 1'b1;
                  rden_q  <= 1'b1;
                  addr_q  <= '0;
               end
            end
            CNT_RD: begin
               state_q <= CNT_WAIT;
               wait_q  <= 1'b0;
            end
            CNT_WAIT: begin
               if (!wait_q) begin
                  wait_q <= 1'b1;
               end else begin
                  count_q <= cnt_sat;
                  if (cnt_sat == '0) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     // First particle read goes out with the state change;
                     // the pipeline is empty so no occupancy check is needed.
                     rden_q      <= 1'b1;
                     addr_q      <= ADDR_WIDTH'(1);
                     next_addr_q <= ADDR_WIDTH'(2);
                     state_q     <= (cnt_sat == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                  end
               end
            end
            STREAM: begin
               if (can_issue) begin
                  rden_q      <= 1'b1;
                  addr_q      <= next_addr_q;
                  next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                  if (next_addr_q == count_q) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && pos_last) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read-return alignment and output FIFO.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         st1_vld_q  <= 1'b0;
         st2_vld_q  <= 1'b0;
         st1_addr_q <= '0;
         st2_addr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      end else begin
         st1_vld_q  <= rd_trk;
         st1_addr_q <= addr_q;
         st2_vld_q  <= st1_vld_q;
         st2_addr_q <= st1_addr_q;
         if (push) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= {mem_q, st2_addr_q, (st2_addr_q == count_q)};
            wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
   end

`ifdef CELL_POS_READER_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (state_q == IDLE && start) begin
         stall_q <= '0;
      end else if (busy_q && pos_valid && !pos_ready && stall_q != '1) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cell_pos_reader.sv
// Testbench for cell_pos_reader: behavioural 2-cycle memory, expected-beat
// queue built from the memory contents at start, per-cycle checks of busy,
// done, read addresses, outstanding reads, beat contents and stall count.
module tb_cell_pos_reader;

   logic         clock = 1'b0;
   logic         rst_n, start, pos_ready;
   logic         busy, done, mem_rden, mem_wren, pos_last, pos_valid;
   logic [7:0]   mem_address, pos_index;
   logic [95:0]  mem_q, pos_data, rd1;
   logic [15:0]  stall_cycles;

   logic [95:0]  mem [256];

   typedef struct packed {
      logic [95:0] d;
      logic [7:0]  idx;
      logic        last;
   } beat_t;

   beat_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc_n = 0, start_cyc = 0, zero_done_cyc = -1, next_rd = -1, mcount = 0;
   int issued = 0, accepted = 0, first_acc_cyc = 0, last_acc_cyc = 0, stall_exp = 0;
   bit mbusy = 0, first_seen = 0, exp_done = 0;

   cell_pos_reader #(
      .DATA_WIDTH  (96),
      .ADDR_WIDTH  (8),
      .PARTICLE_NUM(220),
      .FIFO_DEPTH  (4)
   ) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_address (mem_address),
      .mem_rden    (mem_rden),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q),
      .pos_data    (pos_data),
      .pos_index   (pos_index),
      .pos_last    (pos_last),
      .pos_valid   (pos_valid),
      .pos_ready   (pos_ready),
      .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   // Position memory: data appears two cycles after the read request.
   always @(posedge clock) begin
      rd1   <= mem_rden ? mem[mem_address] : {$urandom, $urandom, $urandom};
      mem_q <= rd1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_mem(input int field);
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
      mem[0][7:0] = field[7:0];
   endtask

   // One clock: update the reference model with what the DUT sampled at the
   // edge, then check every observable output for the new cycle.
   task automatic step();
      bit s_start, s_rst, s_acc, s_last, s_stall, b_before;
      logic [127:0] e;
      int c;
      s_start  = start;
      s_rst    = rst_n;
      b_before = mbusy;
      s_acc    = pos_valid && pos_ready;
      s_stall  = mbusy && pos_valid && !pos_ready;
      s_last   = 0;
      if (s_acc && exp_q.size() > 0) begin
         s_last = exp_q[0].last;
         void'(exp_q.pop_front());
      end
      @(posedge clock);
      #1;
      cyc_n++;
      exp_done = 0;
      if (!s_rst) begin
         mbusy = 0; exp_q.delete(); next_rd = -1; mcount = 0;
         issued = 0; accepted = 0; stall_exp = 0; zero_done_cyc = -1;
      end else begin
         if (s_stall && stall_exp < 65535) stall_exp++;
         if (s_acc) begin
            accepted++;
            if (accepted == 1) first_acc_cyc = cyc_n;
            last_acc_cyc = cyc_n;
            if (s_last) begin exp_done = 1; mbusy = 0; end
         end
         if (cyc_n == zero_done_cyc) begin exp_done = 1; mbusy = 0; zero_done_cyc = -1; end
         if (s_start && !b_before) begin
            mbusy = 1; start_cyc = cyc_n; next_rd = 0; first_seen = 0;
            issued = 0; accepted = 0; stall_exp = 0;
            c = int'(mem[0][7:0]);
            if (c > 219) c = 219;
            mcount = c;
            exp_q.delete();
            for (int i = 1; i <= c; i++) exp_q.push_back('{d: mem[i], idx: 8'(i), last: (i == c)});
            if (c == 0) zero_done_cyc = cyc_n + 3;
         end
      end

      chk("busy", busy, mbusy);
      chk("done", done, exp_done);
      chk("mem_wren", mem_wren, 0);
      if (mem_rden) begin
         if (mem_address != 8'd0) issued++;
         e = (next_rd < 0 || next_rd > mcount) ? 128'h1FF : 128'(next_rd);
         chk("rd_addr", mem_address, e);
         next_rd++;
      end
      chk("outstanding_gt_4", (issued - accepted) > 4, 0);
      if (pos_valid) begin
         if (exp_q.size() == 0) chk("unexpected_valid", pos_valid, 0);
         else begin
            if (!first_seen) begin
               chk("first_valid_latency", 128'(cyc_n - start_cyc), 6);
               first_seen = 1;
            end
            chk("pos_data", pos_data, exp_q[0].d);
            chk("pos_index", pos_index, exp_q[0].idx);
            chk("pos_last", pos_last, exp_q[0].last);
         end
      end
`ifdef CELL_POS_READER_PERF_EN
      chk("stall_cycles", stall_cycles, stall_exp);
`else
      chk("stall_cycles", stall_cycles, 0);
`endif
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // mode 0: ready always 1, 1: one high then three low, 2: random
   task automatic run_until_done(input int budget, input int mode);
      int ph = 0;
      for (int i = 0; i < budget; i++) begin
         case (mode)
            0: pos_ready = 1'b1;
            1: pos_ready = (ph % 4 == 0);
            default: pos_ready = ($urandom_range(0, 3) != 0);
         endcase
         ph++;
         step();
         if (done) return;
      end
      chk("timeout_waiting_done", done, 1);
   endtask

   task automatic check_all_zero();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rden", mem_rden, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_valid", pos_valid, 0);
      chk("rst_data", pos_data, 0);
      chk("rst_index", pos_index, 0);
      chk("rst_last", pos_last, 0);
      chk("rst_stall", stall_cycles, 0);
   endtask

   initial begin
      int n;
      bit found;
      rst_n = 1'b0; start = 1'b0; pos_ready = 1'b1;
      load_mem(5);

      // Reset state
      step(); step();
      check_all_zero();
      rst_n = 1'b1;
      step();

      // Count 5, ready always high: consecutive beats
      load_mem(5);
      pulse_start();
      run_until_done(60, 0);
      chk("c5_beats", accepted, 5);
      chk("c5_consecutive", 128'(last_acc_cyc - first_acc_cyc), 4);
      step();

      // Count 0: done three cycles after start, no particle reads
      load_mem(0);
      pulse_start();
      run_until_done(20, 0);
      chk("c0_done_cycle", 128'(cyc_n - start_cyc), 3);
      chk("c0_beats", accepted, 0);
      step(); step();

      // Count 10 with ready 1 high / 3 low
      load_mem(10);
      pulse_start();
      run_until_done(200, 1);
      chk("c10_beats", accepted, 10);
      pos_ready = 1'b1;
      step();

      // Count field 250 saturates to 219
      load_mem(250);
      pulse_start();
      run_until_done(2000, 2);
      chk("sat_beats", accepted, 219);
      pos_ready = 1'b1;
      step();

      // Reset mid-stream at particle 3 of 8, then full restart
      load_mem(8);
      pulse_start();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (pos_valid && pos_index == 8'd3) found = 1;
         else step();
      end
      chk("reach_particle3", found, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_all_zero();
      for (int i = 0; i < 12; i++) step();
      pulse_start();
      run_until_done(60, 0);
      chk("restart_beats", accepted, 8);
      step();

      // Start while busy ignored; back-to-back start in the done cycle
      load_mem(4);
      pulse_start();
      step();
      pulse_start();
      run_until_done(60, 0);
      chk("busy_start_beats", accepted, 4);
      pulse_start();
      chk("b2b_rden", mem_rden, 1);
      chk("b2b_addr", mem_address, 0);
      run_until_done(60, 0);
      chk("b2b_beats", accepted, 4);
      step();

      // Random cells with random backpressure
      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(1, 12);
         load_mem(n);
         pulse_start();
         run_until_done(300, 2);
         chk("rand_beats", accepted, n);
         pos_ready = 1'b1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
